// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch (I) port and
// the data (D) port. Runs one transaction at a time. D has fixed priority,
// except that fetch is forced through after STARVE_LIMIT back-to-back D grants
// made while fetch was waiting. A bus timeout aborts transactions whose
// memory ack never arrives.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transaction; choose a winner, pulse Valid of previous txn
// WAIT_I | fetch read issued, MemReq_o high, waiting for MemAck_i
// WAIT_D | data read/write issued, MemReq_o high, waiting for MemAck_i
module mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    IReq_i,
  input  logic [ADDR_WIDTH-1:0]   IAddr_i,
  output logic                    IReady_o,
  output logic                    IValid_o,
  output logic [DATA_WIDTH-1:0]   IRData_o,
  input  logic                    DReq_i,
  input  logic                    DWrite_i,
  input  logic [ADDR_WIDTH-1:0]   DAddr_i,
  input  logic [DATA_WIDTH-1:0]   DWData_i,
  input  logic [DATA_WIDTH/8-1:0] DByteEn_i,
  output logic                    DReady_o,
  output logic                    DValid_o,
  output logic [DATA_WIDTH-1:0]   DRData_o,
  output logic                    Err_o,
  output logic                    MemReq_o,
  output logic                    MemWrite_o,
  output logic [ADDR_WIDTH-1:0]   MemAddr_o,
  output logic [DATA_WIDTH-1:0]   MemWData_o,
  output logic [DATA_WIDTH/8-1:0] MemByteEn_o,
  input  logic [DATA_WIDTH-1:0]   MemRData_i,
  input  logic                    MemAck_i
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int ST_W = $clog2(STARVE_LIMIT + 1);
  localparam int TO_W = $clog2(TIMEOUT);
  localparam logic [ST_W-1:0] STARVE_MAX = ST_W'(STARVE_LIMIT);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [ST_W-1:0] starve_cnt, starve_n;
  logic [TO_W-1:0] to_cnt, to_n;
  logic            mem_write_r;
  logic            d_win, i_win;
  logic            ivalid_n, dvalid_n, err_n;
  logic [DATA_WIDTH-1:0] irdata_n, drdata_n;

  // Grant selection, starvation bookkeeping, ack/timeout handling
  always_comb begin
    state_n  = state;
    starve_n = starve_cnt;
    to_n     = to_cnt;
    d_win    = 1'b0;
    i_win    = 1'b0;
    ivalid_n = 1'b0;
    dvalid_n = 1'b0;
    err_n    = 1'b0;
    irdata_n = '0;
    drdata_n = '0;
    case (state)
      IDLE: begin
        // Ready is gated by rst so nothing looks accepted while in reset.
        d_win = rst && DReq_i && !(IReq_i && (starve_cnt == STARVE_MAX));
        i_win = rst && IReq_i && !d_win;
        to_n  = '0;
        if (d_win) begin
          state_n = WAIT_D;
          // A D win with fetch pending implies starve_cnt < STARVE_MAX,
          // so the increment cannot overflow past the limit.
          starve_n = IReq_i ? starve_cnt + 1'b1 : '0;
        end else if (i_win) begin
          state_n  = WAIT_I;
          starve_n = '0;
        end
      end
      WAIT_I, WAIT_D: begin
        if (MemAck_i) begin
          state_n = IDLE;
          if (state == WAIT_I) begin
            ivalid_n = 1'b1;
            irdata_n = MemRData_i;
          end else begin
            dvalid_n = 1'b1;
            drdata_n = mem_write_r ? '0 : MemRData_i;
          end
        end else if (to_cnt == TO_LAST) begin
          state_n  = IDLE;
          err_n    = 1'b1;
          ivalid_n = (state == WAIT_I);
          dvalid_n = (state == WAIT_D);
        end else begin
          to_n = to_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      to_cnt     <= '0;
      IValid_o   <= 1'b0;
      DValid_o   <= 1'b0;
      Err_o      <= 1'b0;
      IRData_o   <= '0;
      DRData_o   <= '0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      to_cnt     <= to_n;
      IValid_o   <= ivalid_n;
      DValid_o   <= dvalid_n;
      Err_o      <= err_n;
      IRData_o   <= irdata_n;
      DRData_o   <= drdata_n;
    end
  end

  // Request fields captured on the accept edge and held through WAIT
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_write_r <= 1'b0;
      MemAddr_o   <= '0;
      MemWData_o  <= '0;
      MemByteEn_o <= '0;
    end else if (d_win) begin
      mem_write_r <= DWrite_i;
      MemAddr_o   <= DAddr_i;
      MemWData_o  <= DWData_i;
      MemByteEn_o <= DByteEn_i;
    end else if (i_win) begin
      mem_write_r <= 1'b0;
      MemAddr_o   <= IAddr_i;
      MemWData_o  <= '0;
      MemByteEn_o <= {BE_W{1'b1}};
    end
  end

  assign IReady_o   = i_win;
  assign DReady_o   = d_win;
  assign MemReq_o   = (state != IDLE);
  assign MemWrite_o = mem_write_r && (state == WAIT_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a response scoreboard. Stimulus
// pushes the expected Valid response when it issues an ack (or knows a
// timeout is coming); the monitor pops and compares on every Valid pulse.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        IReq_i;
  logic [31:0] IAddr_i;
  logic        IReady_o;
  logic        IValid_o;
  logic [31:0] IRData_o;
  logic        DReq_i;
  logic        DWrite_i;
  logic [31:0] DAddr_i;
  logic [31:0] DWData_i;
  logic [3:0]  DByteEn_i;
  logic        DReady_o;
  logic        DValid_o;
  logic [31:0] DRData_o;
  logic        Err_o;
  logic        MemReq_o;
  logic        MemWrite_o;
  logic [31:0] MemAddr_o;
  logic [31:0] MemWData_o;
  logic [3:0]  MemByteEn_o;
  logic [31:0] MemRData_i;
  logic        MemAck_i;

  mem_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .IReq_i(IReq_i), .IAddr_i(IAddr_i), .IReady_o(IReady_o),
    .IValid_o(IValid_o), .IRData_o(IRData_o),
    .DReq_i(DReq_i), .DWrite_i(DWrite_i), .DAddr_i(DAddr_i),
    .DWData_i(DWData_i), .DByteEn_i(DByteEn_i), .DReady_o(DReady_o),
    .DValid_o(DValid_o), .DRData_o(DRData_o), .Err_o(Err_o),
    .MemReq_o(MemReq_o), .MemWrite_o(MemWrite_o), .MemAddr_o(MemAddr_o),
    .MemWData_o(MemWData_o), .MemByteEn_o(MemByteEn_o),
    .MemRData_i(MemRData_i), .MemAck_i(MemAck_i)
  );

  typedef struct {
    logic        is_d;
    logic        err;
    logic [31:0] data;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;
  int    pass_cnt  = 0;
  int    total_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: every Valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (IValid_o || DValid_o) begin
      total_cnt++;
      if (IValid_o && DValid_o) begin
        $display("FAIL resp_both: IValid and DValid high together at %0t", $time);
      end else if (exp_q.size() == 0) begin
        $display("FAIL resp_unexpected: IValid=%b DValid=%b with nothing expected at %0t",
                 IValid_o, DValid_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (DValid_o !== mon_e.is_d || Err_o !== mon_e.err ||
            (mon_e.is_d ? DRData_o : IRData_o) !== mon_e.data)
          $display("FAIL resp: got is_d=%b err=%b data=%h expected is_d=%b err=%b data=%h",
                   DValid_o, Err_o, mon_e.is_d ? DRData_o : IRData_o,
                   mon_e.is_d, mon_e.err, mon_e.data);
        else pass_cnt++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic is_d, input logic err, input logic [31:0] data);
    resp_t e;
    e.is_d = is_d;
    e.err  = err;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for a Ready, returns who won and whether DValid was
  // high in that same cycle, then steps past the accept edge.
  task automatic wait_grant(output logic gi, output logic gd, output logic dv);
    logic ok;
    ok = 1'b0;
    gi = 1'b0;
    gd = 1'b0;
    dv = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (IReady_o || DReady_o) begin
        gi = IReady_o;
        gd = DReady_o;
        dv = DValid_o;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total_cnt++;
      $display("FAIL grant_wait: no Ready within 50 cycles, required a grant");
    end
    cyc();
  endtask

  logic gi, gd, dv;
  int   n;
  logic [1:0] order_exp [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    IReq_i = 1'b0; IAddr_i = '0;
    DReq_i = 1'b1; DWrite_i = 1'b0; DAddr_i = 32'h44; DWData_i = '0; DByteEn_i = 4'hf;
    MemRData_i = '0; MemAck_i = 1'b0;

    // Reset: all outputs low, no Ready even with a request pending
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_ready", {IReady_o, DReady_o}, 2'b00);
    chk("rst_valid_err", {IValid_o, DValid_o, Err_o}, 3'b000);
    chk("rst_mem_ctl", {MemReq_o, MemWrite_o}, 2'b00);
    chk("rst_mem_addr_be", {MemAddr_o, 28'd0, MemByteEn_o}, 64'd0);
    chk("rst_rdata", {IRData_o, DRData_o}, 64'd0);
    DReq_i = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();

    // Single I read, ack three cycles after accept
    IReq_i = 1'b1; IAddr_i = 32'hBFC0_0000;
    wait_grant(gi, gd, dv);
    IReq_i = 1'b0;
    chk("i_grant", {gi, gd}, 2'b10);
    @(negedge clk);
    chk("i_memreq", {MemReq_o, MemWrite_o}, 2'b10);
    chk("i_memaddr", MemAddr_o, 32'hBFC0_0000);
    chk("i_membe", MemByteEn_o, 4'hf);
    cyc(); cyc();
    MemAck_i = 1'b1; MemRData_i = 32'h0050_0093;
    push_exp(1'b0, 1'b0, 32'h0050_0093);
    cyc();
    MemAck_i = 1'b0;
    @(negedge clk);
    chk("i_latency", {IValid_o, MemReq_o}, 2'b10);
    cyc();

    // D write: read data on the response must be 0
    DReq_i = 1'b1; DWrite_i = 1'b1; DAddr_i = 32'h0001_0000;
    DWData_i = 32'hAABB_CCDD; DByteEn_i = 4'b0011;
    wait_grant(gi, gd, dv);
    DReq_i = 1'b0;
    chk("dw_grant", {gi, gd}, 2'b01);
    @(negedge clk);
    chk("dw_memctl", {MemReq_o, MemWrite_o}, 2'b11);
    chk("dw_memaddr", MemAddr_o, 32'h0001_0000);
    chk("dw_memwdata", MemWData_o, 32'hAABB_CCDD);
    chk("dw_membe", MemByteEn_o, 4'b0011);
    cyc();
    MemAck_i = 1'b1; MemRData_i = 32'hFFFF_FFFF;
    push_exp(1'b1, 1'b0, 32'h0);
    cyc();
    MemAck_i = 1'b0;
    cyc();

    // D read at minimum latency: ack in the first WAIT cycle
    DReq_i = 1'b1; DWrite_i = 1'b0; DAddr_i = 32'h0000_2000; DByteEn_i = 4'hf;
    wait_grant(gi, gd, dv);
    DReq_i = 1'b0;
    MemAck_i = 1'b1; MemRData_i = 32'h1234_5678;
    push_exp(1'b1, 1'b0, 32'h1234_5678);
    cyc();
    MemAck_i = 1'b0;
    @(negedge clk);
    chk("dr_min_latency", {DValid_o, MemReq_o}, 2'b10);
    cyc();

    // Both requesters held: D,D,D,D,I repeating; acks back-to-back
    order_exp[0] = 2'b01; order_exp[1] = 2'b01; order_exp[2] = 2'b01; order_exp[3] = 2'b01;
    order_exp[4] = 2'b10; order_exp[5] = 2'b01; order_exp[6] = 2'b01; order_exp[7] = 2'b01;
    order_exp[8] = 2'b01; order_exp[9] = 2'b10;
    IReq_i = 1'b1; IAddr_i = 32'h0000_0100;
    DReq_i = 1'b1; DWrite_i = 1'b0; DAddr_i = 32'h0000_3000;
    for (int i = 0; i < 10; i++) begin
      wait_grant(gi, gd, dv);
      chk($sformatf("starve_order_%0d", i), {gi, gd}, order_exp[i]);
      if (i == 4) chk("b2b_dvalid_iready", {dv, gi}, 2'b11);
      MemAck_i = 1'b1; MemRData_i = 32'hA000_0000 + 32'(i);
      push_exp(gd, 1'b0, 32'hA000_0000 + 32'(i));
      cyc();
      MemAck_i = 1'b0;
      if (i == 9) begin
        IReq_i = 1'b0;
        DReq_i = 1'b0;
      end
    end
    cyc();

    // Timeout in WAIT_I: MemReq_o stays up for TIMEOUT cycles
    IReq_i = 1'b1; IAddr_i = 32'h0000_0040;
    wait_grant(gi, gd, dv);
    IReq_i = 1'b0;
    push_exp(1'b0, 1'b1, 32'h0);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!MemReq_o) break;
      n++;
    end
    chk("to_memreq_cycles", 64'(n), 64'd64);
    chk("to_valid_err", {IValid_o, Err_o, IRData_o}, {2'b11, 32'h0});
    cyc();

    // Reset mid-WAIT_D aborts with no response; stale ack afterwards ignored
    DReq_i = 1'b1; DWrite_i = 1'b0; DAddr_i = 32'h0000_0200;
    wait_grant(gi, gd, dv);
    DReq_i = 1'b0;
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_memreq", {MemReq_o, DValid_o, IValid_o}, 3'b000);
    cyc();
    MemAck_i = 1'b1; MemRData_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stale_ack_%0d", i), {MemReq_o, DValid_o, IValid_o, Err_o}, 4'b0000);
      cyc();
    end
    MemAck_i = 1'b0;
    repeat (3) cyc();

    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
